// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready stream bundle for ram_fifo_ctrl: input stream s_* and output stream m_*.
// The controller connects through the slave modport; the environment uses the master modport.
interface ram_fifo_ctrl_if #(
    parameter int WIDTH = 11
) ();
    logic [WIDTH-1:0] s_tdata;
    logic             s_tvalid;
    logic             s_tready;
    logic [WIDTH-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;

    modport slave (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid
    );

    modport master (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Stream-to-RAM FIFO controller with a 2-entry output buffer that hides the 1-cycle RAM read latency.
// Defining RAM_FIFO_STATS_EN adds a high-watermark register on max_count; otherwise max_count is 0.
module ram_fifo_ctrl #(
    parameter  int WIDTH = 11,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 3)
) (
    input  logic             aclk,
    input  logic             aresetn,
    ram_fifo_ctrl_if.slave   strm,
    output logic [AW-1:0]    ram_waddr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_we,
    output logic [AW-1:0]    ram_raddr,
    output logic             ram_re,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    max_count
);
    localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);

    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic             inflight_reg;
    logic [1:0]       occ_reg, occ_next;
    logic [WIDTH-1:0] buf0_reg, buf0_next;
    logic [WIDTH-1:0] buf1_reg, buf1_next;

    logic [AW:0] ram_count;
    logic        ram_full, ram_empty;
    logic        push, pop, rd_issue;
    logic [2:0]  occ_after;

    // Full/empty come only from registered pointers, so a read never chases a same-cycle write.
    assign ram_count = wr_ptr_reg - rd_ptr_reg;
    assign ram_full  = (ram_count == DEPTH_P);
    assign ram_empty = (ram_count == '0);

    assign strm.s_tready = !ram_full;
    assign strm.m_tvalid = (occ_reg != 2'd0);
    assign strm.m_tdata  = buf0_reg;

    assign push = strm.s_tvalid && !ram_full;
    assign pop  = strm.m_tvalid && strm.m_tready;

    // Buffer slots already claimed next cycle: held words plus the word on its way back from RAM.
    assign occ_after = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign rd_issue  = !ram_empty && (occ_after < 3'd2);

    assign ram_we    = push;
    assign ram_waddr = wr_ptr_reg[AW-1:0];
    assign ram_wdata = strm.s_tdata;
    assign ram_re    = rd_issue;
    assign ram_raddr = rd_ptr_reg[AW-1:0];

    assign count = CW'(ram_count) + CW'(inflight_reg) + CW'(occ_reg);

    // buf0 is always the head; a pop shifts buf1 forward and the returning RAM word lands behind it.
    always_comb begin
        buf0_next = buf0_reg;
        buf1_next = buf1_reg;
        occ_next  = occ_reg;
        case ({pop, inflight_reg})
            2'b10: begin
                buf0_next = buf1_reg;
                occ_next  = occ_reg - 2'd1;
            end
            2'b01: begin
                if (occ_reg == 2'd0) begin
                    buf0_next = ram_rdata;
                end else begin
                    buf1_next = ram_rdata;
                end
                occ_next = occ_reg + 2'd1;
            end
            2'b11: begin
                if (occ_reg == 2'd1) begin
                    buf0_next = ram_rdata;
                end else begin
                    buf0_next = buf1_reg;
                    buf1_next = ram_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            inflight_reg <= 1'b0;
            occ_reg      <= 2'd0;
            buf0_reg     <= '0;
            buf1_reg     <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            inflight_reg <= rd_issue;
            occ_reg      <= occ_next;
            buf0_reg     <= buf0_next;
            buf1_reg     <= buf1_next;
        end
    end

`ifdef RAM_FIFO_STATS_EN
    logic [CW-1:0] max_count_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            max_count_reg <= '0;
        end else if (count > max_count_reg) begin
            max_count_reg <= count;
        end
    end

    assign max_count = max_count_reg;
`else
    assign max_count = '0;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: a queue scoreboard models FIFO contents, order and occupancy.
// Includes a behavioural 16x11 read-first dual-port RAM behind the controller.
module tb_ram_fifo_ctrl;
    localparam int WIDTH = 11;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 5;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    ram_fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [WIDTH-1:0] ram_wdata, ram_rdata;
    logic             ram_we, ram_re;
    logic [CW-1:0]    count, max_count;

    ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .strm      (bus.slave),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_raddr (ram_raddr),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata),
        .count     (count),
        .max_count (max_count)
    );

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge aclk) begin
        if (ram_re) ram_rdata <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the FIFO is simply the ordered list of accepted-but-not-popped words.
    logic [WIDTH-1:0] sb_q[$];
    int               model_max;
    int               max_seen;
    logic             obs_mvalid, obs_stready;
    logic [WIDTH-1:0] obs_mdata;
    logic [CW-1:0]    obs_count;
    bit               push_seen, pop_seen;
    int               wraps;
    logic [AW-1:0]    last_waddr;

    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
        int exp_max;
        @(posedge aclk);
        #1;
        bus.s_tvalid = v;
        bus.s_tdata  = d;
        bus.m_tready = r;
        @(negedge aclk);
        obs_mvalid  = bus.m_tvalid;
        obs_mdata   = bus.m_tdata;
        obs_stready = bus.s_tready;
        obs_count   = count;
        push_seen   = v && bus.s_tready;
        pop_seen    = bus.m_tvalid && r;
`ifdef RAM_FIFO_STATS_EN
        exp_max = model_max;
`else
        exp_max = 0;
`endif
        check("count", 32'(count), 32'(sb_q.size()));
        check("max_count", 32'(max_count), 32'(exp_max));
        if (ram_re && ram_we) check("rw_collision", 32'(ram_raddr == ram_waddr), 32'(0));
        if (ram_we) begin
            if (last_waddr == AW'(DEPTH - 1) && ram_waddr == '0) wraps++;
            last_waddr = ram_waddr;
        end
        if (pop_seen) begin
            if (sb_q.size() == 0) check("spurious_valid", 32'(bus.m_tvalid), 32'(0));
            else check("data", 32'(bus.m_tdata), 32'(sb_q.pop_front()));
        end
        if (push_seen) sb_q.push_back(d);
        if (sb_q.size() > model_max) model_max = sb_q.size();
        if (int'(count) > max_seen) max_seen = int'(count);
    endtask

    task automatic do_reset();
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.m_tready = 1'b0;
        aresetn      = 1'b0;
        sb_q.delete();
        model_max = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        int tries, n_push, n_pop, first_pop, last_pop, cyc;
        logic [WIDTH-1:0] rd;
        wraps      = 0;
        last_waddr = '0;
        max_seen   = 0;
        do_reset();

        // Reset state
        check("rst_stready", 32'(bus.s_tready), 32'(1));
        check("rst_mvalid", 32'(bus.m_tvalid), 32'(0));
        check("rst_mdata", 32'(bus.m_tdata), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_ram_re", 32'(ram_re), 32'(0));

        // Single word latency
        for (int k = 0; k < 5; k++) begin
            cycle(k == 0, 11'h5A3, 1'b1);
            if (k < 3) check("single_mvalid_early", 32'(obs_mvalid), 32'(0));
            if (k == 3) begin
                check("single_mvalid", 32'(obs_mvalid), 32'(1));
                check("single_mdata", 32'(obs_mdata), 32'h5A3);
            end
            if (k == 4) check("single_after_pop", 32'(obs_count), 32'(0));
        end

        // Fill with backpressure: 18 words fit (2 buffered, 16 in RAM)
        for (int i = 0; i < 18; i++) begin
            tries = 0;
            do begin
                cycle(1'b1, 11'(i), 1'b0);
                tries++;
            end while (!push_seen && tries < 20);
            check("fill_accept", 32'(push_seen), 32'(1));
        end
        cycle(1'b1, 11'h3FF, 1'b0);
        check("full_stready", 32'(obs_stready), 32'(0));
        check("full_count", 32'(obs_count), 32'(18));
        check("full_no_push", 32'(push_seen), 32'(0));
        cycle(1'b0, 11'h0, 1'b0);

        // Drain in order without bubbles
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, 11'h0, 1'b1);
            check("drain_pop", 32'(pop_seen), 32'(1));
        end
        cycle(1'b0, 11'h0, 1'b1);
        check("drained_mvalid", 32'(obs_mvalid), 32'(0));
        check("drained_count", 32'(obs_count), 32'(0));

        // Streaming with address wrap
        do_reset();
        wraps = 0;
        last_waddr = '0;
        n_push = 0; n_pop = 0; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 43; i++) begin
            cycle(i < 40, 11'(12'h100 + i), 1'b1);
            if (push_seen) n_push++;
            if (pop_seen) begin
                n_pop++;
                if (first_pop < 0) first_pop = i;
                last_pop = i;
            end
        end
        check("stream_push", 32'(n_push), 32'(40));
        check("stream_pop", 32'(n_pop), 32'(40));
        check("stream_first", 32'(first_pop), 32'(3));
        check("stream_span", 32'(last_pop - first_pop), 32'(39));
        check("stream_wraps", 32'(wraps), 32'(2));

        // Random valid/ready over 1000 accepted words
        n_push = 0;
        cyc = 0;
        while (n_push < 1000 && cyc < 20000) begin
            rd = 11'($urandom);
            cycle(1'($urandom % 2), rd, 1'($urandom % 2));
            if (push_seen) n_push++;
            cyc++;
        end
        check("rand_pushes", 32'(n_push), 32'(1000));
        cyc = 0;
        while (sb_q.size() > 0 && cyc < 100) begin
            cycle(1'b0, 11'h0, 1'b1);
            cyc++;
        end
        check("rand_drained", 32'(sb_q.size()), 32'(0));
        check("count_bound", 32'(max_seen <= 18), 32'(1));

        // Reset in the middle of operation with 10 words held
        for (int i = 0; i < 10; i++) cycle(1'b1, 11'(12'h200 + i), 1'b0);
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        bus.s_tvalid = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'(0));
        check("midrst_mvalid", 32'(bus.m_tvalid), 32'(0));
        check("midrst_stready", 32'(bus.s_tready), 32'(1));
        sb_q.delete();
        model_max = 0;
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        check("release_count", 32'(count), 32'(0));
        check("release_mvalid", 32'(bus.m_tvalid), 32'(0));
        check("release_stready", 32'(bus.s_tready), 32'(1));
        for (int k = 0; k < 5; k++) begin
            cycle(k == 0, 11'h7FF, 1'b1);
            check("post_rst_mvalid", 32'(obs_mvalid), 32'(k == 3));
            if (k == 3) check("post_rst_mdata", 32'(obs_mdata), 32'h7FF);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
